// File: rtl/fifo_lookahead_upsizer_if.sv
// Handshake bundle between the upsizer, its upstream lookahead FIFO read port
// and its downstream FIFO write port.
interface fifo_lookahead_upsizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 2
);
  // Upstream lookahead FIFO read side
  logic                        i_empty;
  logic                        i_rd;
  logic [DATA_WIDTH-1:0]       i_data;
  // Control
  logic                        flush;
  logic                        busy;
  // Downstream FIFO write side
  logic                        o_full;
  logic                        o_wr;
  logic [DATA_WIDTH*RATIO-1:0] o_data;
  logic [$clog2(RATIO+1)-1:0]  o_words;

  // The packer itself
  modport slave (
    input  i_empty, i_data, flush, o_full,
    output i_rd, o_wr, o_data, o_words, busy
  );

  // Whatever surrounds the packer (FIFOs, control)
  modport master (
    output i_empty, i_data, flush, o_full,
    input  i_rd, o_wr, o_data, o_words, busy
  );
endinterface

// File: rtl/fifo_lookahead_upsizer.sv
// Width-upsizing packer: pops a lookahead FIFO, concatenates RATIO words
// (first word in lane 0) and writes the packed word downstream. A flush
// emits a partially filled, zero-padded word together with its lane count.
module fifo_lookahead_upsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_lookahead_upsizer_if.slave bus
);
  localparam int CNT_W     = $clog2(RATIO);
  localparam int WORDS_W   = $clog2(RATIO + 1);
  localparam int WORD_BITS = DATA_WIDTH * RATIO;

  // Pack state
  logic [CNT_W-1:0]     r_count;
  logic                 r_flush_pending;
  // Output register
  logic                 r_out_valid;
  logic [WORD_BITS-1:0] r_out_data;
  logic [WORDS_W-1:0]   r_out_words;

  logic                 w_wr;
  logic                 w_rd;
  logic                 w_out_free;
  logic                 w_last_lane;
  logic                 w_pop_full;
  logic                 w_flush_load;
  logic                 w_clear;
  logic [WORD_BITS-1:0] w_pack_flat;
  logic [WORD_BITS-1:0] w_full_word;

  // Downstream write whenever a word is held and there is room; never in reset.
  assign w_wr        = !rst && r_out_valid && !bus.o_full;
  // Output register can accept a new word at this edge.
  assign w_out_free  = !r_out_valid || w_wr;
  assign w_last_lane = (r_count == CNT_W'(RATIO - 1));
  // Pop while lanes remain, or when the completing pop has somewhere to go.
  // A pending flush freezes the pack so the partial word is well defined.
  assign w_rd        = !rst && !bus.i_empty && !r_flush_pending &&
                       (!w_last_lane || w_out_free);
  assign w_pop_full  = w_rd && w_last_lane;
  // Partial emission: only when something is packed and the output is free.
  assign w_flush_load = r_flush_pending && (r_count != '0) && w_out_free;
  assign w_clear      = w_pop_full || w_flush_load;

  // Completed word: stored lanes plus the word being popped in the top lane.
  assign w_full_word = {bus.i_data, w_pack_flat[WORD_BITS-DATA_WIDTH-1:0]};

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] r_lane;

      // Capture the popped word into its lane; lanes return to zero whenever
      // the pack is emitted so partial words are zero-padded for free.
      always_ff @(posedge clk) begin
        if (rst || w_clear) begin
          r_lane <= '0;
        end else if (w_rd && (r_count == CNT_W'(gi))) begin
          r_lane <= bus.i_data;
        end
      end

      assign w_pack_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_lane;
    end
  endgenerate

  // Lane counter, output register and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count         <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_out_words     <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_wr) begin
        r_out_valid <= 1'b0;
      end

      if (w_pop_full) begin
        r_out_data  <= w_full_word;
        r_out_words <= WORDS_W'(RATIO);
        r_out_valid <= 1'b1;
        r_count     <= '0;
      end else if (w_flush_load) begin
        r_out_data  <= w_pack_flat;
        r_out_words <= WORDS_W'(r_count);
        r_out_valid <= 1'b1;
        r_count     <= '0;
      end else if (w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end

      // A flush arriving while one is pending is absorbed by the pending one.
      if (r_flush_pending) begin
        if ((r_count == '0) || w_out_free) begin
          r_flush_pending <= 1'b0;
        end
      end else if (bus.flush) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  assign bus.i_rd    = w_rd;
  assign bus.o_wr    = w_wr;
  assign bus.o_data  = r_out_data;
  assign bus.o_words = r_out_words;
  assign bus.busy    = !rst && ((r_count != '0) || r_out_valid || r_flush_pending);

endmodule

// File: tb/tb_fifo_lookahead_upsizer.sv
// Self-checking bench: directed RATIO=2 scenarios plus a randomized RATIO=4
// stream checked by reconstructing the input word sequence from the writes.
module tb_fifo_lookahead_upsizer;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_lookahead_upsizer_if #(.DATA_WIDTH(DW), .RATIO(2)) bus2 ();
  fifo_lookahead_upsizer_if #(.DATA_WIDTH(DW), .RATIO(4)) bus4 ();

  fifo_lookahead_upsizer #(.DATA_WIDTH(DW), .RATIO(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  fifo_lookahead_upsizer #(.DATA_WIDTH(DW), .RATIO(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  w;
    int          t;
  } cap2_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          tk = 0;
  logic [31:0] src2[$];
  logic [31:0] src4[$];
  logic [31:0] exp4[$];
  cap2_t       cap2[$];
  bit          rd_at[4096];
  bit          wr_at[4096];
  bit          busy_at[4096];
  int          pops2 = 0;
  int          pops4 = 0;
  int          written4 = 0;
  int          flushes4 = 0;
  int          partials4 = 0;
  int          max_held4 = 0;
  bit          hold4 = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("mismatch on %s", tag);
    end
  endtask

  task automatic refresh2();
    bus2.i_empty = (src2.size() == 0);
    bus2.i_data  = (src2.size() != 0) ? src2[0] : 32'h0;
  endtask

  task automatic refresh4();
    bus4.i_empty = (src4.size() == 0) || hold4;
    bus4.i_data  = (src4.size() != 0) ? src4[0] : 32'h0;
  endtask

  // One clock of the RATIO=2 instance: sample mid-cycle, then apply pops.
  task automatic tick2();
    logic rd;
    @(negedge clk);
    rd = bus2.i_rd;
    if (tk < 4096) begin
      rd_at[tk]   = rd;
      wr_at[tk]   = bus2.o_wr;
      busy_at[tk] = bus2.busy;
    end
    if (bus2.o_wr) cap2.push_back('{bus2.o_data, bus2.o_words, tk});
    if (rd) pops2++;
    tk++;
    @(posedge clk);
    #1;
    if (rd) void'(src2.pop_front());
    bus2.flush = 1'b0;
    refresh2();
  endtask

  // One clock of the RATIO=4 instance with scoreboard on every write.
  task automatic tick4();
    logic        rd;
    int          n;
    int          held;
    logic [127:0] e;
    @(negedge clk);
    rd   = bus4.i_rd;
    held = pops4 - written4;
    if (held > max_held4) max_held4 = held;
    if (bus4.o_wr) begin
      n = int'(bus4.o_words);
      chk("stress_words_range", (n >= 1 && n <= 4), 1'b1);
      if (n != 4) begin
        partials4++;
        chk("stress_partial_has_flush", (partials4 <= flushes4), 1'b1);
      end
      if (n > 4) n = 4;
      e = '0;
      for (int i = 0; i < n; i++) begin
        if (exp4.size() != 0) e[i*32 +: 32] = exp4.pop_front();
      end
      chk("stress_data", bus4.o_data, e);
      written4 += n;
    end
    if (rd) pops4++;
    @(posedge clk);
    #1;
    if (rd) void'(src4.pop_front());
    bus4.flush = 1'b0;
    refresh4();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick2();
    tick2();
    rst = 1'b0;
    cap2.delete();
    src2.delete();
    pops2 = 0;
    bus2.o_full = 1'b0;
    refresh2();
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [63:0] d, input logic [1:0] w);
    if (idx < cap2.size()) begin
      chk({tag, "_data"}, cap2[idx].d, d);
      chk({tag, "_words"}, cap2[idx].w, w);
    end else begin
      chk({tag, "_count"}, cap2.size(), idx + 1);
    end
  endtask

  initial begin
    int t0;
    int tf;
    int tr;
    int lw;
    int nb;
    int guard;
    logic [31:0] w;

    bus2.i_empty = 1'b1; bus2.i_data = '0; bus2.flush = 1'b0; bus2.o_full = 1'b0;
    bus4.i_empty = 1'b1; bus4.i_data = '0; bus4.flush = 1'b0; bus4.o_full = 1'b0;

    // Reset state
    rst = 1'b1;
    tick2();
    tick2();
    chk("rst_rd", rd_at[1], 1'b0);
    chk("rst_wr", wr_at[1], 1'b0);
    chk("rst_busy", busy_at[1], 1'b0);
    rst = 1'b0;
    chk("rst_odata", bus2.o_data, 64'h0);
    chk("rst_owords", bus2.o_words, 2'd0);
    chk("rst_busy_after", bus2.busy, 1'b0);
    chk("rst4_owords", bus4.o_words, 3'd0);

    // Streaming: two full words in pair cadence
    src2 = '{32'h5A, 32'hF6, 32'h09, 32'hC4};
    refresh2();
    t0 = tk;
    repeat (8) tick2();
    chk("stream_nwr", cap2.size(), 2);
    chk_wr("stream_w0", 0, 64'h000000F6_0000005A, 2'd2);
    chk_wr("stream_w1", 1, 64'h000000C4_00000009, 2'd2);
    if (cap2.size() >= 2) begin
      chk("stream_latency", cap2[0].t - t0, 2);
      chk("stream_cadence", cap2[1].t - cap2[0].t, 2);
    end

    // Backpressure: at most 2*RATIO-1 words absorbed while full
    do_reset();
    src2 = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81, 32'hE2, 32'hA0, 32'h7A};
    bus2.o_full = 1'b1;
    refresh2();
    repeat (20) tick2();
    chk("bp_pops", pops2, 3);
    chk("bp_no_wr", cap2.size(), 0);
    chk("bp_rd_low", rd_at[tk-1], 1'b0);
    bus2.o_full = 1'b0;
    for (int g = 0; g < 40 && cap2.size() < 4; g++) tick2();
    chk("bp_nwr", cap2.size(), 4);
    chk_wr("bp_w0", 0, 64'h000000F6_0000005A, 2'd2);
    chk_wr("bp_w1", 1, 64'h000000C4_00000009, 2'd2);
    chk_wr("bp_w2", 2, 64'h000000E2_00000081, 2'd2);
    chk_wr("bp_w3", 3, 64'h0000007A_000000A0, 2'd2);

    // Partial flush
    do_reset();
    src2 = '{32'h5A, 32'hF6, 32'h09};
    refresh2();
    repeat (5) tick2();
    bus2.flush = 1'b1;
    tf = tk;
    repeat (6) tick2();
    chk("pf_nwr", cap2.size(), 2);
    chk_wr("pf_w0", 0, 64'h000000F6_0000005A, 2'd2);
    chk_wr("pf_w1", 1, 64'h00000000_00000009, 2'd1);
    if (cap2.size() >= 2) begin
      lw = cap2[1].t;
      chk("pf_latency", lw - tf, 2);
      chk("pf_busy_at_wr", busy_at[lw], 1'b1);
      chk("pf_busy_after", busy_at[lw+1], 1'b0);
    end

    // Empty flush: busy for exactly one cycle, nothing written
    do_reset();
    bus2.flush = 1'b1;
    tf = tk;
    repeat (5) tick2();
    nb = 0;
    for (int i = 0; i < 5; i++) nb += int'(busy_at[tf+i]);
    chk("ef_busy_cycles", nb, 1);
    chk("ef_busy_second", busy_at[tf+1], 1'b1);
    chk("ef_nwr", cap2.size(), 0);

    // Flush together with the word-completing pop
    do_reset();
    src2 = '{32'h5A, 32'hF6};
    refresh2();
    tick2();
    bus2.flush = 1'b1;
    tick2();
    repeat (6) tick2();
    chk("fc_nwr", cap2.size(), 1);
    chk_wr("fc_w0", 0, 64'h000000F6_0000005A, 2'd2);
    chk("fc_busy_end", busy_at[tk-1], 1'b0);

    // Reset mid-operation with a stalled full word and a half-filled pack
    do_reset();
    src2 = '{32'h81, 32'hE2, 32'h09};
    bus2.o_full = 1'b1;
    refresh2();
    repeat (3) tick2();
    rst = 1'b1;
    bus2.o_full = 1'b0;
    tr = tk;
    tick2();
    rst = 1'b0;
    chk("rm_wr_in_rst", wr_at[tr], 1'b0);
    chk("rm_busy_in_rst", busy_at[tr], 1'b0);
    chk("rm_busy_after", bus2.busy, 1'b0);
    src2 = '{32'hA0, 32'h7A};
    refresh2();
    repeat (6) tick2();
    chk("rm_nwr", cap2.size(), 1);
    chk_wr("rm_w0", 0, 64'h0000007A_000000A0, 2'd2);

    // Random stress, RATIO=4
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      src4.push_back(w);
      exp4.push_back(w);
    end
    refresh4();
    guard = 0;
    while (written4 < 1024 && guard < 30000) begin
      bus4.o_full = ($urandom_range(0, 2) == 0);
      hold4       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 63) == 0 || (src4.size() == 0 && (guard % 16) == 0)) begin
        bus4.flush = 1'b1;
        flushes4++;
      end
      refresh4();
      tick4();
      guard++;
    end
    chk("stress_no_timeout", (guard < 30000), 1'b1);
    chk("stress_written", written4, 1024);
    chk("stress_popped", pops4, 1024);
    chk("stress_leftover", exp4.size(), 0);
    chk("stress_max_held", (max_held4 <= 7), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
